// File: rtl/pls_dac_sample_output_if.sv
// Float32 sample stream between the pulse generator core and the DAC stage.
// The generator drives the master side; the DAC stage is the slave.
interface pls_dac_sample_output_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/pls_dac_sample_output.sv
// Float32 -> DAC code converter with credit-based FIFO and tick-paced output.
// Define PLS_DAC_OFFSET_BINARY_EN for offset-binary dac_data coding.
module pls_dac_sample_output #(
  parameter int DAC_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16,
  localparam int LW = $clog2(FIFO_DEPTH + 1),
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  pls_dac_sample_output_if.slave s,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] rate_div,
  input  logic                 clr_underrun,
  output logic [DAC_WIDTH-1:0] dac_data,
  output logic                 dac_strobe,
  output logic                 underrun,
  output logic [LW-1:0]        fifo_level
);

  typedef struct packed {
    logic                 v;
    logic                 sgn;
    logic                 sat;
    logic [DAC_WIDTH-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic                 v;
    logic [DAC_WIDTH-1:0] code;
  } s2_t;

  localparam logic [DAC_WIDTH-1:0] CODE_MAX =
    {1'b0, {(DAC_WIDTH-1){1'b1}}};
  localparam logic [DAC_WIDTH-1:0] CODE_MIN =
    {1'b1, {(DAC_WIDTH-1){1'b0}}};

`ifdef PLS_DAC_OFFSET_BINARY_EN
  localparam logic [DAC_WIDTH-1:0] OUT_MASK = CODE_MIN;
`else
  localparam logic [DAC_WIDTH-1:0] OUT_MASK = '0;
`endif

  // Right shift that maps 2^e onto 2^(e+DAC_WIDTH-1): 23-(exp-127+W-1)
  localparam logic [8:0] SH_BASE = 9'(151 - DAC_WIDTH);

  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;

  logic [DAC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DIV_WIDTH-1:0] cnt, rate_q, rate_eff;
  logic                 tick, push, pop, fire;
  logic [LW:0]          credit_used;
  logic [7:0]           exp8;
  logic [22:0]          frac;
  logic [23:0]          mant;
  logic [8:0]           sh;
  logic                 is_zero;

  assign exp8 = s.tdata[30:23];
  assign frac = s.tdata[22:0];
  assign mant = {1'b1, frac};
  assign sh   = SH_BASE - {1'b0, exp8};
  assign fire = s.tvalid & s.tready;

  // Zero, denormals and NaN all map to code 0
  assign is_zero = (exp8 == 8'd0) ||
                   ((exp8 == 8'hFF) && (frac != 23'd0));

  always_comb begin
    s1_d     = '0;
    s1_d.v   = fire;
    s1_d.sgn = s.tdata[31];
    s1_d.sat = !is_zero && (exp8 >= 8'd127);
    if (!is_zero && (exp8 < 8'd127))
      s1_d.mag = DAC_WIDTH'(mant >> sh);
  end

  always_comb begin
    s2_d   = '0;
    s2_d.v = s1_q.v;
    unique case (1'b1)
      s1_q.sat && s1_q.sgn:  s2_d.code = CODE_MIN;
      s1_q.sat && !s1_q.sgn: s2_d.code = CODE_MAX;
      !s1_q.sat && s1_q.sgn: s2_d.code = DAC_WIDTH'(-s1_q.mag);
      default:               s2_d.code = s1_q.mag;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  // Credits count words in flight so the pipeline never needs to stall
  assign credit_used = {1'b0, fifo_level} +
                       (LW+1)'(s1_q.v) + (LW+1)'(s2_q.v);
  assign s.tready = aresetn &&
                    (credit_used < (LW+1)'(FIFO_DEPTH));

  // A new rate_div is sampled only when the counter sits at 0
  assign rate_eff = (cnt == '0) ? rate_div : rate_q;
  assign tick     = enable && (cnt == rate_eff);
  assign push     = s2_q.v;
  assign pop      = tick && (fifo_level != '0);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt    <= '0;
      rate_q <= '0;
    end else begin
      if (cnt == '0)
        rate_q <= rate_div;
      if (!enable || tick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      mem[wr_ptr] <= s2_q.code;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dac_data   <= OUT_MASK;
      dac_strobe <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dac_strobe <= tick;
      if (pop)
        dac_data <= mem[rd_ptr] ^ OUT_MASK;
      if (tick && !pop)
        underrun <= 1'b1;
      else if (clr_underrun)
        underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pls_dac_sample_output.sv
// Directed bench for pls_dac_sample_output (DAC_WIDTH=16, FIFO_DEPTH=16).
// Expected codes are hand-derived constants plus a real-arithmetic model.
module tb_pls_dac_sample_output;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] rate_div;
  logic        clr_underrun;
  logic [15:0] dac_data;
  logic        dac_strobe;
  logic        underrun;
  logic [4:0]  fifo_level;

  int n_vec = 0;
  int n_err = 0;

  pls_dac_sample_output_if s_if ();

  pls_dac_sample_output dut (
    .aclk         (clk),
    .aresetn      (aresetn),
    .s            (s_if),
    .enable       (enable),
    .rate_div     (rate_div),
    .clr_underrun (clr_underrun),
    .dac_data     (dac_data),
    .dac_strobe   (dac_strobe),
    .underrun     (underrun),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] enc(logic [15:0] c);
`ifdef PLS_DAC_OFFSET_BINARY_EN
    return c ^ 16'h8000;
`else
    return c;
`endif
  endfunction

  function automatic logic [15:0] ref_code(logic [31:0] f);
    int  ex;
    real v;
    int  c;
    ex = int'(f[30:23]);
    if (ex == 0) return 16'h0000;
    if (ex == 255) begin
      if (f[22:0] != 23'd0) return 16'h0000;
      return f[31] ? 16'h8000 : 16'h7FFF;
    end
    v = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (ex - 127));
    if (v >= 1.0) return f[31] ? 16'h8000 : 16'h7FFF;
    c = $rtoi(v * 32768.0);
    if (f[31]) c = -c;
    return 16'(c);
  endfunction

  function automatic logic [31:0] rnd_float();
    logic [7:0]  e;
    logic [31:0] r;
    int          k;
    k = $urandom_range(0, 19);
    if (k == 0)      e = 8'd0;
    else if (k == 1) e = 8'd255;
    else             e = 8'($urandom_range(105, 129));
    r = $urandom;
    return {r[31], e, r[22:0]};
  endfunction

  task automatic send(logic [31:0] d);
    s_if.tdata  = d;
    s_if.tvalid = 1'b1;
    cyc();
    s_if.tvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    cyc();
    aresetn = 1'b1;
    cyc();
  endtask

  logic [31:0] t1_in  [7];
  logic [15:0] t1_exp [7];
  logic [31:0] fv;
  logic        hs;
  int          n_xfer;
  int          sent;
  int          ncyc;
  logic [15:0] exp_q [$];

  initial begin
    t1_in  = '{32'h3F000000, 32'hBE800000, 32'h3F800000, 32'hBF800000,
               32'h40000000, 32'h7FC00000, 32'h00000001};
    t1_exp = '{16'h4000, 16'hE000, 16'h7FFF, 16'h8000,
               16'h7FFF, 16'h0000, 16'h0000};

    aresetn      = 1'b0;
    enable       = 1'b0;
    rate_div     = 16'd0;
    clr_underrun = 1'b0;
    s_if.tdata   = 32'd0;
    s_if.tvalid  = 1'b0;
    #1;
    chk("rst_tready", s_if.tready, 0);
    chk("rst_level", fifo_level, 0);
    cyc();
    chk("rst_dac", dac_data, enc(16'h0000));
    chk("rst_strobe", dac_strobe, 0);
    chk("rst_underrun", underrun, 0);
    aresetn = 1'b1;
    cyc();
    chk("post_rst_tready", s_if.tready, 1);

    // Conversion vectors, one per strobe at rate_div=0
    for (int i = 0; i < 7; i++) send(t1_in[i]);
    cyc(); cyc(); cyc();
    chk("t1_level", fifo_level, 7);
    chk("t1_nostrobe", dac_strobe, 0);
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("t1_strobe%0d", i), dac_strobe, 1);
      chk($sformatf("t1_code%0d", i), dac_data, enc(t1_exp[i]));
    end
    cyc();
    chk("t1_underrun", underrun, 1);
    chk("t1_hold", dac_data, enc(16'h0000));
    enable       = 1'b0;
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    chk("t1_clr", underrun, 0);

    // Fill with output stopped: credits cap transfers at FIFO_DEPTH
    n_xfer      = 0;
    s_if.tdata  = 32'h3F000000;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if (s_if.tready) n_xfer++;
      cyc();
    end
    s_if.tvalid = 1'b0;
    chk("t3_xfers", n_xfer, 16);
    chk("t3_level", fifo_level, 16);
    chk("t3_tready_lo", s_if.tready, 0);
    rate_div = 16'd3;
    enable   = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk($sformatf("t3_strobe_c%0d", i), dac_strobe, (i % 4) == 0);
      if (i == 4) begin
        chk("t3_level_pop1", fifo_level, 15);
        chk("t3_tready_hi", s_if.tready, 1);
        chk("t3_code", dac_data, enc(16'h4000));
      end
    end
    chk("t3_level_pop2", fifo_level, 14);
    enable = 1'b0;
    pulse_reset();
    chk("t3_rst_level", fifo_level, 0);

    // Underrun and clear priority
    send(32'h3F000000);
    send(32'hBF000000);
    cyc(); cyc(); cyc();
    chk("t4_level", fifo_level, 2);
    rate_div = 16'd1;
    enable   = 1'b1;
    cyc();
    chk("t4_e1_strobe", dac_strobe, 0);
    cyc();
    chk("t4_e2_strobe", dac_strobe, 1);
    chk("t4_e2_code", dac_data, enc(16'h4000));
    cyc();
    cyc();
    chk("t4_e4_strobe", dac_strobe, 1);
    chk("t4_e4_code", dac_data, enc(16'hC000));
    chk("t4_e4_nounder", underrun, 0);
    cyc();
    cyc();
    chk("t4_e6_strobe", dac_strobe, 1);
    chk("t4_e6_underrun", underrun, 1);
    chk("t4_e6_hold", dac_data, enc(16'hC000));
    clr_underrun = 1'b1;
    cyc();
    chk("t4_clr_notick", underrun, 0);
    cyc();
    chk("t4_tick_strobe", dac_strobe, 1);
    chk("t4_set_wins", underrun, 1);
    clr_underrun = 1'b0;
    enable       = 1'b0;

    // Reset with 5 words queued and 2 in flight
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      s_if.tdata = 32'h3F400000;
      cyc();
    end
    chk("t5_level_pre", fifo_level, 5);
    s_if.tvalid = 1'b0;
    aresetn     = 1'b0;
    #1;
    chk("t5_async_level", fifo_level, 0);
    chk("t5_async_tready", s_if.tready, 0);
    chk("t5_async_dac", dac_data, enc(16'h0000));
    chk("t5_async_under", underrun, 0);
    cyc();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t5_nostrobe%0d", i), dac_strobe, 0);
    end
    chk("t5_dropped", fifo_level, 0);
    send(32'h3E000000);
    cyc(); cyc(); cyc();
    chk("t5_level_new", fifo_level, 1);
    rate_div = 16'd0;
    enable   = 1'b1;
    cyc();
    chk("t5_strobe", dac_strobe, 1);
    chk("t5_code", dac_data, enc(16'h1000));

    // Random traffic against the real-arithmetic model
    clr_underrun = 1'b1;
    sent = 0;
    ncyc = 0;
    while ((sent < 2000 || exp_q.size() != 0) && ncyc < 40000) begin
      if (ncyc % 50 == 0) rate_div = 16'($urandom_range(0, 7));
      fv          = rnd_float();
      s_if.tdata  = fv;
      s_if.tvalid = (sent < 2000) && ($urandom_range(0, 3) != 0);
      hs          = s_if.tvalid && s_if.tready;
      if (hs) begin
        exp_q.push_back(ref_code(fv));
        sent++;
      end
      cyc();
      ncyc++;
      if (dac_strobe && !underrun) begin
        chk("rnd_expected_word", exp_q.size() != 0, 1);
        if (exp_q.size() != 0)
          chk("rnd_code", dac_data, enc(exp_q.pop_front()));
      end
    end
    s_if.tvalid = 1'b0;
    chk("rnd_sent", sent, 2000);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_level", fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
